// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one producer at a time access to a shared FIFO,
// allowing up to BURST_MAX writes per grant and stalling cleanly on fifo_full.
module fifo_wr_arbiter #(
   parameter int NREQ      = 4,
   parameter int DW        = 8,
   parameter int BURST_MAX = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [NREQ*DW-1:0]   req_data,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 fifo_full,
   output logic                 wr,
   output logic [DW-1:0]        wr_data,
   output logic [NREQ-1:0]      grant,
   output logic                 busy
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   gidx;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   sel_idx;
   logic [IW-1:0]   next_ptr;
   logic            sel_found;
   logic            g_valid;
   logic            xfer;
   logic            release_now;
   logic [3:0]      burst_cnt;

   // First valid requester at or above rr_ptr, wrapping modulo NREQ.
   always_comb begin
      logic [IW-1:0] k;
      k         = '0;
      sel_found = 1'b0;
      sel_idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         k = IW'((int'(rr_ptr) + i) % NREQ);
         if (!sel_found && req_valid[k]) begin
            sel_found = 1'b1;
            sel_idx   = k;
         end
      end
   end

   assign g_valid     = req_valid[gidx];
   assign xfer        = (state == GRANT) & g_valid & ~fifo_full;
   assign release_now = (state == GRANT) &
                        (~g_valid | (xfer & (burst_cnt == 4'(BURST_MAX - 1))));
   assign next_ptr    = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (sel_found)   state_nxt = GRANT;
         GRANT:   if (release_now) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      req_ready = '0;
      wr        = 1'b0;
      wr_data   = '0;
      busy      = 1'b0;
      if (state == GRANT) begin
         busy            = 1'b1;
         req_ready[gidx] = ~fifo_full;
         wr              = xfer;
         wr_data         = req_data[int'(gidx)*DW +: DW];
      end
   end

   // Grant bookkeeping: owner index, one-hot grant, burst counter, round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant     <= '0;
         gidx      <= '0;
         burst_cnt <= '0;
         rr_ptr    <= '0;
      end else if (state == IDLE) begin
         if (sel_found) begin
            gidx      <= sel_idx;
            grant     <= {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
            burst_cnt <= '0;
         end
      end else begin
         if (xfer) burst_cnt <= burst_cnt + 4'd1;
         if (release_now) begin
            grant  <= '0;
            rr_ptr <= next_ptr;
         end
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic, compared each cycle
// against a requester-level round-robin model kept in integers and queues.
module tb_fifo_wr_arbiter;

   localparam int NREQ  = 4;
   localparam int DW    = 8;
   localparam int BURST = 4;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [NREQ-1:0]     req_valid;
   logic [NREQ*DW-1:0]  req_data;
   logic [NREQ-1:0]     req_ready;
   logic                fifo_full;
   logic                wr;
   logic [DW-1:0]       wr_data;
   logic [NREQ-1:0]     grant;
   logic                busy;

   fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .BURST_MAX(BURST)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .fifo_full (fifo_full),
      .wr        (wr),
      .wr_data   (wr_data),
      .grant     (grant),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // Producer queues and reference model state.
   logic [DW-1:0] src_q[NREQ][$];
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] cur_data[NREQ];
   logic [NREQ-1:0] cur_valid;
   int m_owner;
   int m_count;
   int m_ptr;
   int wr_cnt;
   logic [NREQ-1:0] prev_grant;
   logic [NREQ-1:0] gseq[$];
   logic [NREQ-1:0] exp_seq[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
   endtask

   task automatic model_reset();
      m_owner    = -1;
      m_count    = 0;
      m_ptr      = 0;
      prev_grant = '0;
      exp_q.delete();
   endtask

   // One clock cycle, entered just after a falling edge.
   task automatic step(input logic full_in);
      logic [NREQ-1:0] e_grant;
      logic [NREQ-1:0] e_ready;
      logic            e_wr;
      logic [DW-1:0]   e_data;
      fifo_full = full_in;
      for (int i = 0; i < NREQ; i++) begin
         cur_valid[i] = (src_q[i].size() > 0);
         cur_data[i]  = cur_valid[i] ? src_q[i][0] : DW'($urandom);
         req_data[i*DW +: DW] = cur_data[i];
      end
      req_valid = cur_valid;
      #1;
      e_grant = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
      e_ready = (m_owner >= 0 && !full_in) ? e_grant : '0;
      e_wr    = (m_owner >= 0) && cur_valid[m_owner] && !full_in;
      e_data  = (m_owner >= 0) ? cur_data[m_owner] : '0;
      check("grant", grant, e_grant);
      check("busy", busy, (m_owner >= 0));
      check("req_ready", req_ready, e_ready);
      check("wr", wr, e_wr);
      check("wr_data", wr_data, e_data);
      check("grant_onehot0", $onehot0(grant), 1'b1);
      check("wr_while_full", wr & fifo_full, 1'b0);
      if (e_wr) exp_q.push_back(e_data);
      if (wr === 1'b1) begin
         wr_cnt++;
         if (exp_q.size() > 0) check("sb_data", wr_data, exp_q.pop_front());
         else                  check("sb_spurious_wr", 1, 0);
      end
      if (grant !== '0 && grant !== prev_grant) gseq.push_back(grant);
      prev_grant = grant;
      // Advance the reference model by one cycle.
      if (e_wr) begin
         void'(src_q[m_owner].pop_front());
         m_count++;
      end
      if (m_owner < 0) begin
         for (int k = 0; k < NREQ; k++) begin
            int c;
            c = (m_ptr + k) % NREQ;
            if (m_owner < 0 && cur_valid[c]) begin
               m_owner = c;
               m_count = 0;
            end
         end
      end else if (!cur_valid[m_owner] || m_count == BURST) begin
         m_ptr   = (m_owner + 1) % NREQ;
         m_owner = -1;
      end
      @(negedge clk);
   endtask

   function automatic int pending();
      int n = 0;
      for (int i = 0; i < NREQ; i++) n += src_q[i].size();
      return n;
   endfunction

   task automatic drain(input string tag);
      int guard = 0;
      while ((pending() > 0 || m_owner >= 0) && guard < 300) begin
         step(1'b0);
         guard++;
      end
      check({tag, "_drained"}, (pending() == 0 && m_owner < 0), 1'b1);
      check({tag, "_sb_empty"}, exp_q.size(), 0);
   endtask

   task automatic check_seq(input string tag);
      check({tag, "_gseq_len"}, gseq.size(), exp_seq.size());
      for (int i = 0; i < exp_seq.size() && i < gseq.size(); i++)
         check({tag, "_gseq"}, gseq[i], exp_seq[i]);
   endtask

   task automatic load(input int r, input int n);
      for (int i = 0; i < n; i++) src_q[r].push_back(DW'($urandom));
   endtask

   task automatic begin_scenario();
      gseq.delete();
      wr_cnt = 0;
   endtask

   initial begin
      int guard;
      rst_n     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      fifo_full = 1'b0;
      model_reset();
      #1;
      check("rst_grant", grant, 0);
      check("rst_busy", busy, 0);
      check("rst_wr", wr, 0);
      check("rst_ready", req_ready, 0);
      check("rst_wr_data", wr_data, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // All requesters continuously valid: rotation 0,1,2,3,0 with full bursts.
      begin_scenario();
      load(0, 8); load(1, 4); load(2, 4); load(3, 4);
      drain("all_valid");
      exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
      check_seq("all_valid");
      check("all_valid_writes", wr_cnt, 20);

      // Single requester with 6 words: burst of 4, idle, re-grant for 2.
      begin_scenario();
      load(0, 6);
      drain("single");
      exp_seq = '{4'b0001, 4'b0001};
      check_seq("single");
      check("single_writes", wr_cnt, 6);

      // Early release: requester 1 runs dry after 2 words, next valid above it is 3.
      begin_scenario();
      load(1, 2); load(3, 4); load(0, 4);
      drain("early_rel");
      exp_seq = '{4'b0010, 4'b1000, 4'b0001};
      check_seq("early_rel");
      check("early_rel_writes", wr_cnt, 10);

      // Full stall for 3 cycles in the middle of a burst.
      begin_scenario();
      load(2, 4);
      step(1'b0); step(1'b0); step(1'b0);
      step(1'b1); step(1'b1); step(1'b1);
      drain("stall");
      exp_seq = '{4'b0100};
      check_seq("stall");
      check("stall_writes", wr_cnt, 4);

      // Reset mid-burst of grant 0100 with rr_ptr left at 3 beforehand.
      load(2, 4);
      drain("pre_reset");
      load(2, 4);
      guard = 0;
      while (!(m_owner == 2 && m_count == 2) && guard < 20) begin
         step(1'b0);
         guard++;
      end
      check("reset_reach_2_writes", (m_owner == 2 && m_count == 2), 1'b1);
      rst_n = 1'b0;
      #1;
      check("midrst_grant", grant, 0);
      check("midrst_wr", wr, 0);
      check("midrst_busy", busy, 0);
      check("midrst_ready", req_ready, 0);
      check("midrst_wr_data", wr_data, 0);
      model_reset();
      @(negedge clk);
      check("midrst_wr_hold", wr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      begin_scenario();
      load(3, 3);
      drain("post_reset");
      exp_seq = '{4'b0100, 4'b1000};
      check_seq("post_reset");
      check("post_reset_writes", wr_cnt, 5);

      // Random traffic with random FIFO back-pressure.
      begin_scenario();
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 2) == 0) begin
            int r;
            r = $urandom_range(0, NREQ - 1);
            if (src_q[r].size() < 6) load(r, $urandom_range(1, 3));
         end
         step($urandom_range(0, 3) == 0);
      end
      drain("random");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
